// File: rtl/matvec_pkg.sv
// matvec_pkg: shared FSM state type and problem-size constants for the matvec stream driver
package matvec_pkg;
  localparam int MATRIX_SIZE = 3;
  localparam int NUM_WORDS   = MATRIX_SIZE * MATRIX_SIZE + MATRIX_SIZE;
  localparam int NUM_RESULTS = MATRIX_SIZE;
  typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;
endpackage

// File: rtl/matvec_drv_buffer.sv
// matvec_drv_buffer: 12-entry problem buffer (W row-major then X), async active-low clear
//   rst_n          async clear of every entry
//   i_we/i_waddr/i_wdata  host write port; indexes >= NUM_WORDS are dropped
//   i_raddr/o_rdata       combinational read port; out-of-range reads return 0
module matvec_drv_buffer
  import matvec_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [3:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [3:0]       i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [NUM_WORDS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr < 4'(NUM_WORDS))
      r_mem[i_waddr] <= i_wdata;
  assign o_rdata = i_raddr < 4'(NUM_WORDS) ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/matvec_stream_driver.sv
// matvec_stream_driver: streams a loaded 3x3 W and 3-vector X into the accelerator, then collects 3 results
//   reset                   async active-low
//   ld_en/ld_addr/ld_data   host buffer writes (accepted only in IDLE/DONE)
//   start                   launches a run from IDLE/DONE
//   hold_ready              backpressure injection on s_ready
//   rd_addr/rd_data         result readback, 0 for index 3
//   busy/done/cycles        status; cycles counts SEND+COLLECT cycles, saturating
//   m_*                     valid/ready source into the accelerator
//   s_*                     valid/ready sink from the accelerator
module matvec_stream_driver
  import matvec_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int OUT_WIDTH = 28,
  parameter int CYC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_en,
  input  logic [3:0]           ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 start,
  input  logic                 hold_ready,
  input  logic [1:0]           rd_addr,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [CYC_WIDTH-1:0] cycles,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [OUT_WIDTH-1:0] s_data
);
  state_t               r_state;
  logic [3:0]           r_widx;
  logic [1:0]           r_ridx;
  logic [OUT_WIDTH-1:0] r_result [NUM_RESULTS];
  logic                 r_m_valid, r_s_ready, r_busy, r_done;
  logic [CYC_WIDTH-1:0] r_cycles;
  logic                 w_idle, w_m_hs, w_s_hs;
  assign w_idle = r_state == IDLE || r_state == DONE;
  assign w_m_hs = r_m_valid && m_ready;
  assign w_s_hs = s_valid && r_s_ready;
  // m_data follows r_widx, which only moves on a handshake, so data stays stable under backpressure
  matvec_drv_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (ld_en && w_idle),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (r_widx),
    .o_rdata (m_data)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_widx    <= '0;
      r_ridx    <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cycles  <= '0;
      for (int i = 0; i < NUM_RESULTS; i++) r_result[i] <= '0;
    end else begin
      if (r_busy && r_cycles != '1) r_cycles <= r_cycles + 1'b1;
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state   <= SEND;
          r_widx    <= '0;
          r_ridx    <= '0;
          r_cycles  <= '0;
          r_m_valid <= 1'b1;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
        end
        SEND: if (w_m_hs) begin
          r_widx <= r_widx + 1'b1;
          if (r_widx == 4'(NUM_WORDS - 1)) begin
            r_state   <= COLLECT;
            r_m_valid <= 1'b0;
            r_s_ready <= ~hold_ready;
          end
        end
        COLLECT: begin
          r_s_ready <= ~hold_ready;
          if (w_s_hs) begin
            r_result[r_ridx] <= s_data;
            r_ridx           <= r_ridx + 1'b1;
            if (r_ridx == 2'(NUM_RESULTS - 1)) begin
              r_state   <= DONE;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign rd_data = rd_addr < 2'(NUM_RESULTS) ? r_result[rd_addr] : '0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cycles  = r_cycles;
  assign m_valid = r_m_valid;
  assign s_ready = r_s_ready;
endmodule

// File: tb/tb_matvec_stream_driver.sv
// tb_matvec_stream_driver: random-backpressure bench with an accelerator stand-in and a matrix-product reference
module tb_matvec_stream_driver;
  localparam int W  = 14;
  localparam int OW = 28;
  localparam int CW = 16;
  logic          clk = 0, reset = 1, ld_en = 0, start = 0, hold_ready = 0, m_ready = 0, s_valid = 0;
  logic [3:0]    ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  logic [1:0]    rd_addr = '0;
  logic [OW-1:0] s_data = '0;
  logic [OW-1:0] rd_data;
  logic          busy, done, m_valid, s_ready;
  logic [CW-1:0] cycles;
  logic [W-1:0]  m_data;
  logic [W-1:0]  mdl [12];
  int            nvec = 0, nerr = 0, c1, c2;

  matvec_stream_driver dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .hold_ready(hold_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .cycles(cycles), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [OW-1:0] exp);
    rd_addr = a;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic load(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 0;
    if (a < 12) mdl[a] = d;
  endtask

  // One run: bench plays the accelerator, model result is y = W*X on the loaded words
  task automatic run(input int pm, input int ps, input int ph, input int stall, input bit inj,
                     input int abort_at, output int n);
    logic [OW-1:0] y [3];
    longint        acc;
    int            wi, ri;
    bit            pend;
    logic [W-1:0]  prev;
    for (int i = 0; i < 3; i++) begin
      acc = 0;
      for (int j = 0; j < 3; j++)
        acc += longint'($signed(mdl[3*i+j])) * longint'($signed(mdl[9+j]));
      y[i] = acc[OW-1:0];
    end
    wi = 0; ri = 0; pend = 0; prev = '0; n = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    forever begin
      if (abort_at > 0 && ri == abort_at) begin
        m_ready = 0; s_valid = 0; hold_ready = 0; start = 0; ld_en = 0;
        reset = 0;
        #1;
        chk("abort_m_valid", 32'(m_valid), 0);
        chk("abort_s_ready", 32'(s_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cycles", 32'(cycles), 0);
        rdchk("abort_r0", 0, '0);
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 12; i++) mdl[i] = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) rdchk("post_abort_r", 2'(i), '0);
        n = -1;
        return;
      end
      if (done || n > 100000) break;
      if (pend) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(prev));
      end
      if (wi < 12) chk("s_ready_send", 32'(s_ready), 0);
      m_ready    = n >= stall && $urandom_range(99) < pm;
      s_valid    = wi < 12 ? 1'($urandom) : (ri < 3 && $urandom_range(99) < ps);
      s_data     = wi < 12 ? OW'($urandom) : y[ri < 3 ? ri : 0];
      hold_ready = $urandom_range(99) < ph;
      start      = inj && n == 3;
      ld_en      = inj && n == 3;
      ld_addr    = '0;
      ld_data    = W'($urandom);
      pend       = m_valid && !m_ready;
      prev       = m_data;
      if (wi < 12) begin
        if (m_valid && m_ready) begin
          chk("word", 32'(m_data), 32'(mdl[wi]));
          wi++;
        end
      end else chk("m_valid_after", 32'(m_valid), 0);
      if (s_valid && s_ready && wi == 12) ri++;
      @(negedge clk);
      n++;
    end
    m_ready = 0; s_valid = 0; hold_ready = 0; start = 0; ld_en = 0;
    chk("done_end", 32'(done), 1);
    chk("busy_end", 32'(busy), 0);
    chk("cycles", 32'(cycles), n > 65535 ? 65535 : n);
    chk("word_count", wi, 12);
    chk("result_count", ri, 3);
    for (int i = 0; i < 3; i++) rdchk("result", 2'(i), y[i]);
    rdchk("rd3", 3, '0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) mdl[i] = '0;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cycles", 32'(cycles), 0);
    for (int i = 0; i < 4; i++) rdchk("rst_rd", 2'(i), '0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 9; i++) load(4'(i), W'(i + 1));
    for (int i = 0; i < 3; i++) load(4'(9 + i), W'(i + 1));
    run(100, 100, 0, 0, 0, 0, c1);
    rdchk("basic_y0", 0, 28'd14);
    rdchk("basic_y1", 1, 28'd32);
    rdchk("basic_y2", 2, 28'd50);
    run(100, 100, 0, 0, 1, 0, c2);
    chk("rerun_cycles", 32'(cycles), c1);
    rdchk("rerun_y0", 0, 28'd14);
    run(40, 60, 30, 0, 0, 0, c2);
    rdchk("bp_y2", 2, 28'd50);
    for (int i = 0; i < 12; i++) load(4'(i), '0);
    for (int i = 0; i < 3; i++) load(4'(4 * i), W'(-8192));
    load(9, W'(8191));
    run(70, 70, 20, 0, 0, 0, c2);
    rdchk("diag_y0", 0, 28'(-67100672));
    for (int a = 12; a < 16; a++) load(4'(a), W'($urandom));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 12; i++) load(4'(i), W'($urandom));
      run(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), int'($urandom_range(0, 50)), 0, 0, 0, c2);
    end
    run(100, 100, 0, 65540, 0, 0, c2);
    for (int i = 0; i < 12; i++) load(4'(i), W'($urandom));
    run(80, 80, 20, 0, 0, 1, c2);
    run(100, 100, 0, 0, 0, 0, c2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/matvec_stream_driver.md
Name: matvec_stream_driver

Overview:
Host-side initiator for the matrix-vector accelerator's streaming interface. It holds one problem (a 3x3 matrix W and a 3-vector X) loaded by the host. It streams the 12 words into the accelerator's input valid/ready port, then drains the 3 results from the accelerator's output valid/ready port into result registers. It sits between the host/testbench register interface and the accelerator, and is the other end of both accelerator handshakes.

Parameters:
WIDTH, 14, signed data word width sent to the accelerator
OUT_WIDTH, 28, signed result width received from the accelerator
MATRIX_SIZE, 3, matrix dimension; 9 W words plus 3 X words, 12 words total
CYC_WIDTH, 16, width of the start-to-done cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ld_en  in  1  host write strobe into the problem buffer
ld_addr  in  4  buffer index: 0-8 = W row-major, 9-11 = X
ld_data  in  WIDTH  signed word to store
start  in  1  one-cycle pulse that launches a run
hold_ready  in  1  forces s_ready low (backpressure injection)
rd_addr  in  2  result index 0-2
rd_data  out  OUT_WIDTH  combinational read of result[rd_addr]; 0 for rd_addr=3
busy  out  1  high in SEND or COLLECT
done  out  1  high in DONE state
cycles  out  CYC_WIDTH  cycles from start acceptance to done, saturating
m_valid  out  1  to accelerator input_valid
m_ready  in  1  from accelerator input_ready
m_data  out  WIDTH  to accelerator input_data
s_valid  in  1  from accelerator output_valid
s_ready  out  1  to accelerator output_ready
s_data  in  OUT_WIDTH  from accelerator output_data

Behaviour:
- Reset (reset=0, async): state=IDLE; m_valid=0, s_ready=0, busy=0, done=0, cycles=0; word index and result index = 0; all 12 buffer entries and 3 result registers = 0.
- FSM states: IDLE, SEND, COLLECT, DONE.
- IDLE / DONE:
  - ld_en with ld_addr<=11 writes buffer[ld_addr] on the clock edge.
  - ld_addr>=12 is ignored.
  - start moves to SEND; widx=0, ridx=0, cycles=0, done drops.
  - m_valid rises in the cycle after start, carrying buffer[0].
- SEND:
  - m_valid=1; m_data=buffer[widx].
  - On m_valid&&m_ready, widx increments.
  - The handshake with widx=11 moves to COLLECT; m_valid=0 next cycle.
  - m_data/m_valid hold stable while m_ready=0. A valid, once raised, is never withdrawn before its handshake.
  - s_ready=0; any s_valid is ignored.
- COLLECT:
  - s_ready = ~hold_ready. Registered, so it takes effect one cycle after hold_ready changes.
  - On s_valid&&s_ready, result[ridx] <= s_data and ridx increments.
  - The third handshake moves to DONE; s_ready=0 next cycle.
- DONE:
  - done=1 level; results retained until the next start or reset.
  - A start in DONE begins a new run with the current buffer.
- start during SEND/COLLECT is ignored. ld_en during SEND/COLLECT is ignored (buffer frozen).
- cycles increments every cycle in SEND/COLLECT and saturates at all-ones.
- Results are stored as raw OUT_WIDTH bits; no sign or overflow processing.
- Reset mid-run aborts immediately with no partial handshake completion; the accelerator must be reset together with the driver.

Decomposition:
- Package matvec_pkg: state enum (IDLE, SEND, COLLECT, DONE), localparam NUM_WORDS = MATRIX_SIZE*MATRIX_SIZE+MATRIX_SIZE, NUM_RESULTS = MATRIX_SIZE.
- One sub-module, matvec_drv_buffer: 12-entry write/read register file with async active-low clear.
- FSM, handshake and counters stay in the top.

Test Plan:
- Load W=1..9 row-major and X={1,2,3}, start, accelerator attached, m_ready always 1 -> 12 handshakes in order 1..9,1,2,3; results {14,32,50}; done=1; busy=0.
- Same load, m_ready low 3 cycles on word 4 -> m_data holds 5 with m_valid=1 throughout; stream and results unchanged.
- hold_ready=1 for 10 cycles after first s_valid -> no result captured while s_ready=0; results still {14,32,50} in order.
- W diagonal = -8192 (other entries 0), X={8191,0,0} -> result[0]=-67100672, result[1]=0, result[2]=0.
- start pulsed and ld_en to addr 0 during SEND -> ignored; buffer[0] unchanged; a second run from DONE gives identical results and cycles.
- reset low during COLLECT after 1 result -> all outputs 0 immediately; after release, state IDLE and result[0]=0.
